// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin owner of a shared multi-cycle ALU with start/ack
//            handshake and WAIT-state timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDXW    = 2,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 5
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [NREQ-1:0] Req,
    input  logic            AluDone,
    output logic [NREQ-1:0] Grant,
    output logic [IDXW-1:0] GrantIdx,
    output logic            AluStart,
    output logic [NREQ-1:0] Ack,
    output logic            Err,
    output logic            Busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] c_cnt_last = CNTW'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] c_last_rst = IDXW'(NREQ - 1);

    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [IDXW-1:0] r_idx;
    logic            r_start;
    logic [NREQ-1:0] r_ack;
    logic            r_err;
    logic            r_busy;
    logic [IDXW-1:0] r_last;
    logic [CNTW-1:0] r_cnt;

    logic [IDXW-1:0] w_sel;
    logic [NREQ-1:0] w_onehot;
    int              w_idx;

    // Scan from the farthest offset down so the nearest requester after r_last wins.
    always_comb begin
        w_sel = r_last;
        w_idx = 0;
        for (int i = NREQ; i >= 1; i--) begin
            w_idx = (int'(r_last) + i) % NREQ;
            if (Req[w_idx[IDXW-1:0]]) begin
                w_sel = w_idx[IDXW-1:0];
            end
        end
        w_onehot = NREQ'(1) << w_sel;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_start <= 1'b0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= c_last_rst;
            r_cnt   <= '0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|Req) begin
                        r_state <= S_START;
                        r_grant <= w_onehot;
                        r_idx   <= w_sel;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                    r_start <= 1'b0;
                end
                S_WAIT: begin
                    // Done takes precedence over a coincident timeout.
                    if (AluDone) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ack   <= r_grant;
                        r_last  <= r_idx;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_last  <= r_idx;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Grant    = r_grant;
    assign GrantIdx = r_idx;
    assign AluStart = r_start;
    assign Ack      = r_ack;
    assign Err      = r_err;
    assign Busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed self-checking bench for alu_share_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic       Clk;
    logic       Rst;
    logic [3:0] Req;
    logic       AluDone;
    logic [3:0] Grant;
    logic [1:0] GrantIdx;
    logic       AluStart;
    logic [3:0] Ack;
    logic       Err;
    logic       Busy;

    int n_checks = 0;
    int n_fails  = 0;

    alu_share_arbiter #(
        .NREQ(4), .IDXW(2), .TIMEOUT(16), .CNTW(5)
    ) u_dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .AluDone(AluDone),
        .Grant(Grant), .GrantIdx(GrantIdx), .AluStart(AluStart),
        .Ack(Ack), .Err(Err), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
    endtask

    // Steps until AluStart is seen, bounded so a dead DUT still reaches the summary.
    task automatic wait_start(input string tag);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 8 && !seen; t++) begin
            step();
            if (AluStart) seen = 1'b1;
        end
        check_eq(tag, {31'd0, seen}, 32'd1);
    endtask

    logic [1:0] rr_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] prev_bit;
    logic       bad;

    initial begin
        Rst     = 1'b1;
        Req     = 4'b0000;
        AluDone = 1'b0;

        // Reset / idle
        step();
        step();
        Rst = 1'b0;
        check_eq("reset_outputs", {Grant, GrantIdx, AluStart, Ack, Err, Busy}, 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if ({Grant, GrantIdx, AluStart, Ack, Err, Busy} != 13'd0) bad = 1'b1;
        end
        check_eq("idle_10_cycles", {31'd0, bad}, 32'd0);
        AluDone = 1'b1;
        step();
        AluDone = 1'b0;
        step();
        check_eq("idle_done_ignored", {Grant, GrantIdx, AluStart, Ack, Err, Busy}, 32'd0);

        // Single request
        Req = 4'b0010;
        step();
        check_eq("single_grant", {28'd0, Grant}, 32'h2);
        check_eq("single_idx", {30'd0, GrantIdx}, 32'd1);
        check_eq("single_start", {30'd0, AluStart, Busy}, 32'h3);
        step();
        check_eq("single_start_1cyc", {29'd0, AluStart, Busy, Ack != 4'd0}, 32'h2);
        step();
        AluDone = 1'b1;
        step();
        AluDone = 1'b0;
        check_eq("single_ack", {28'd0, Ack}, 32'h2);
        check_eq("single_release", {27'd0, Grant, Busy}, 32'd0);
        Req = 4'b0000;
        step();
        check_eq("single_ack_1cyc", {27'd0, Ack, Err}, 32'd0);

        // Round robin
        do_reset();
        Req = 4'b1111;
        prev_bit = 4'b0000;
        for (int g = 0; g < 6; g++) begin
            wait_start("rr_start");
            check_eq("rr_idx", {30'd0, GrantIdx}, {30'd0, rr_exp[g]});
            check_eq("rr_grant", {28'd0, Grant}, 32'd1 << rr_exp[g]);
            Req = Req | prev_bit;
            step();
            AluDone = 1'b1;
            step();
            AluDone = 1'b0;
            check_eq("rr_ack", {28'd0, Ack}, 32'd1 << rr_exp[g]);
            prev_bit = Ack;
            Req = Req & ~Ack;
        end
        Req = 4'b0000;
        step();
        step();

        // Timeout: fresh reset so Last=3 and requester 2 wins
        do_reset();
        Req = 4'b0100;
        wait_start("to_start");
        check_eq("to_idx", {30'd0, GrantIdx}, 32'd2);
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (Err || !Busy) bad = 1'b1;
        end
        check_eq("to_no_early_err", {31'd0, bad}, 32'd0);
        step();
        check_eq("to_err", {31'd0, Err}, 32'd1);
        check_eq("to_no_ack_release", {27'd0, Ack, Busy}, 32'd0);
        check_eq("to_grant_zero", {28'd0, Grant}, 32'd0);
        Req = 4'b0101;
        step();
        check_eq("to_err_1cyc", {31'd0, Err}, 32'd0);
        check_eq("to_skip_idx", {30'd0, GrantIdx}, 32'd0);
        check_eq("to_skip_grant", {28'd0, Grant}, 32'h1);
        step();
        AluDone = 1'b1;
        step();
        AluDone = 1'b0;
        check_eq("to_next_ack", {28'd0, Ack}, 32'h1);
        Req = 4'b0000;
        step();

        // Boundary: Done in START ignored, Done on the 16th WAIT cycle wins
        Req = 4'b0001;
        wait_start("bnd_start");
        AluDone = 1'b1;
        step();
        AluDone = 1'b0;
        check_eq("bnd_start_done_ignored", {27'd0, Ack, Busy}, 32'h1);
        for (int i = 0; i < 15; i++) step();
        check_eq("bnd_still_waiting", {30'd0, Err, Busy}, 32'h1);
        AluDone = 1'b1;
        step();
        AluDone = 1'b0;
        check_eq("bnd_last_ack", {28'd0, Ack}, 32'h1);
        check_eq("bnd_last_no_err", {31'd0, Err}, 32'd0);
        Req = 4'b0000;
        step();

        // Async reset in WAIT
        Req = 4'b0010;
        wait_start("ar_start");
        step();
        step();
        check_eq("ar_in_wait", {31'd0, Busy}, 32'd1);
        #2;
        Rst = 1'b1;
        #1;
        check_eq("ar_immediate", {26'd0, Grant, Busy, AluStart}, 32'd0);
        #2;
        Rst = 1'b0;
        Req = 4'b1001;
        step();
        check_eq("ar_after_idx", {30'd0, GrantIdx}, 32'd0);
        check_eq("ar_after_grant", {28'd0, Grant}, 32'h1);
        Req = 4'b0000;
        step();
        AluDone = 1'b1;
        step();
        AluDone = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
